// File: rtl/sync_low.sv
`timescale 1ns/1ps
// sync_low: multi-flop metastability synchronizer for one async,
// active-high level whose idle value is 0. Output resets low.
//
// Parameters:
//   STAGES   : flops in the chain (>= 2)
// Ports:
//   clk      : sampling clock, all stages update on rising edge
//   n_rst    : asynchronous active-low reset, clears every stage
//   async_in : asynchronous input, may change at any time
//   sync_out : synchronized level, driven straight from last flop
module sync_low #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic async_in,
    output logic sync_out
);

    generate
        if (STAGES < 2) begin : g_bad_stages
            $error("sync_low: STAGES must be 2 or more");
        end
    endgenerate

    logic [STAGES-1:0] r_stage;
    logic              w_resolved;

    // Only a definite 1 is captured as 1; X/Z settle to 0 so the
    // chain never carries unknowns. Synthesis sees a plain D input.
    assign w_resolved = (async_in === 1'b1);

    // Pure shift chain: nothing between flops, to leave the full
    // period for resolution.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stage <= '0;
        end else begin
            r_stage <= {r_stage[STAGES-2:0], w_resolved};
        end
    end

    assign sync_out = r_stage[STAGES-1];

endmodule

// File: tb/tb_sync_low.sv
`timescale 1ns/1ps
// tb_sync_low: directed and randomized checks of sync_low against
// a sample-history reference model.
module tb_sync_low;

    localparam int STAGES = 2;

    logic clk;
    logic n_rst;
    logic async_in;
    logic sync_out;

    int n_cmp = 0;
    int n_bad = 0;

    bit armed = 0;

    sync_low #(.STAGES(STAGES)) u_dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .async_in (async_in),
        .sync_out (sync_out)
    );

    initial begin
        clk = 1'b0;
        forever #0.5 clk = ~clk;
    end

    task automatic check(input string tag, input logic obs,
                         input logic exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t",
                     tag, obs, exp, $realtime);
        end
    endtask

    // Reference model: output after an edge equals the input sample
    // taken STAGES-1 edges earlier, or 0 if reset intervened. A sample
    // whose input moved inside the setup/hold window may be either.
    realtime t_chg = -10.0;
    bit      hist[$];
    bit      amb[$];

    always @(async_in) t_chg = $realtime;

    always @(negedge n_rst) begin
        hist.delete();
        amb.delete();
    end

    realtime m_e;
    bit      m_v;
    bit      m_a;
    logic    m_r;

    always @(posedge clk) begin
        m_e = $realtime;
        m_v = (async_in === 1'b1);
        m_r = n_rst;
        m_a = (m_e - t_chg) < 0.19;
        #0.1;
        if (t_chg > m_e) m_a = 1'b1;
        if (m_r === 1'b1 && n_rst === 1'b1) begin
            hist.push_back(m_v);
            amb.push_back(m_a);
            if (hist.size() > STAGES) begin
                void'(hist.pop_front());
                void'(amb.pop_front());
            end
        end
    end

    always @(posedge clk) begin
        #0.81;
        if (armed) begin
            if (hist.size() >= STAGES) begin
                if (amb[0])
                    check("legal", (sync_out === 1'b0 ||
                                    sync_out === 1'b1), 1'b1);
                else
                    check("model", sync_out, logic'(hist[0]));
            end else begin
                check("model_rst", sync_out, 1'b0);
            end
        end
    end

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic set_viol(input logic v_old, input logic v_new);
        @(negedge clk) async_in = v_old;
        settle(3);
        @(negedge clk);
        #0.41 async_in = v_new;
        settle(4);
        #0.81 check("setup_settle", sync_out, v_new);
    endtask

    task automatic hold_viol(input logic v_old, input logic v_new);
        @(negedge clk) async_in = v_old;
        settle(3);
        @(posedge clk);
        #0.05 async_in = v_new;
        settle(4);
        #0.81 check("hold_settle", sync_out, v_new);
    endtask

    initial begin
        n_rst    = 1'b1;
        async_in = 1'b0;

        // power-on reset mid-cycle
        #0.25 n_rst = 1'b0;
        armed = 1'b1;
        #0.1 check("por_fast", sync_out, 1'b0);
        settle(2);
        #0.3 check("por_held", sync_out, 1'b0);
        @(posedge clk);
        #0.2 n_rst = 1'b1;
        #0.01 check("por_release", sync_out, 1'b0);

        // normal 1
        settle(2);
        @(negedge clk) async_in = 1'b1;
        @(posedge clk);
        #0.81 check("norm_edge1", sync_out, 1'b0);
        @(posedge clk);
        #0.81 check("norm_edge2", sync_out, 1'b1);

        set_viol(1'b1, 1'b0);
        set_viol(1'b0, 1'b1);
        hold_viol(1'b0, 1'b1);
        hold_viol(1'b1, 1'b0);

        // metastable stream
        @(negedge clk) async_in = 1'bx;
        repeat (200) begin
            @(posedge clk);
            #0.81 check("meta_zero", sync_out, 1'b0);
        end
        @(negedge clk) async_in = 1'b1;
        settle(2);
        #0.81 check("meta_exit", sync_out, 1'b1);

        // reset mid-operation
        settle(2);
        @(negedge clk);
        #0.1 n_rst = 1'b0;
        #0.01 check("mid_rst_fast", sync_out, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #0.81 check("mid_rst_held", sync_out, 1'b0);
        end
        @(posedge clk);
        #0.2 n_rst = 1'b1;
        @(posedge clk);
        #0.81 check("mid_rel_e1", sync_out, 1'b0);
        @(posedge clk);
        #0.81 check("mid_rel_e2", sync_out, 1'b1);

        // randomized traffic, checked by the model every cycle
        repeat (400) begin
            int r;
            realtime off;
            @(posedge clk);
            r = $urandom_range(0, 99);
            if (r < 4) begin
                #0.3 n_rst = 1'b0;
                #0.01 check("rnd_rst", sync_out, 1'b0);
                settle($urandom_range(1, 3));
                #0.2 n_rst = 1'b1;
            end else if (r < 60) begin
                off = $urandom_range(1, 990) / 1000.0;
                #off;
                if ($urandom_range(0, 9) == 0)
                    async_in = 1'bx;
                else
                    async_in = 1'($urandom_range(0, 1));
            end
        end

        settle(3);
        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_low.md
# sync_low

Two-flop metastability synchronizer for a single asynchronous, active-high control input whose inactive value is 0. It sits at the clock-domain boundary, between an asynchronous source (pin, foreign-domain flag) and logic clocked by `clk`. It re-times the input through a chain of flip-flops, so downstream logic sees only a clean, clock-aligned 0/1 level. Its reset drives the output low.

## Interface
- `STAGES`, default 2: number of flip-flops in the chain. Legal range is 2 or more; values below 2 are rejected by an elaboration-time check.

- `clk` input 1: sampling clock; all stages update on the rising edge.
- `n_rst` input 1: reset. One clock; reset is asynchronous and active-low.
- `async_in` input 1: asynchronous input. It may change at any time relative to `clk`, including inside setup/hold windows.
- `sync_out` input→output 1: synchronized copy of `async_in`, driven directly from the last flop. There is no combinational path from `async_in` to `sync_out`.

## Operation
- The design is a shift chain `stage[0..STAGES-1]`:
  - `stage[0] <= resolve(async_in)`.
  - `stage[i] <= stage[i-1]`.
  - `sync_out = stage[STAGES-1]`.
- `resolve()`: the first stage captures exactly 1 only when `async_in` is a definite 1. Any other value (0, X, Z) is captured as 0.
  - Synthesis treats this as a plain D input.
  - In simulation it models metastability decay: a non-0/1 input must never produce X/Z on any stage.
- Reset (`n_rst` = 0):
  - Every stage is cleared to 0 immediately, without waiting for a clock edge.
  - `sync_out` = 0 for as long as reset is held, regardless of `clk` or `async_in`.
- Reset release: the chain stays at 0 until new input data propagates. There is no spurious 1 on release.
- No enable, no edge detection, no glitch filtering. A pulse on `async_in` shorter than one clock period may be missed; this is acceptable by design.
- Setup or hold violations at stage 0 may resolve to either the old or the new value. The output must still be a legal 0/1, and it must settle to the input's stable value after the normal latency.
- The block has no internal state other than the flop chain.

## Timing
- Latency: a value on `async_in` that is stable across rising edge N appears on `sync_out` after rising edge N+STAGES-1. With the default, the value is captured on edge N and visible after edge N+1, i.e. 2 rising edges after it is applied between edges.
- After any input change, `sync_out` is valid and stable by clk→Q (< 1 ns) after the qualifying edge. It holds until the next edge.
- Reset assertion takes effect asynchronously, within one flop reset delay. Release is expected away from a rising edge, at least the hold time (≥ 0.1 ns) after it.
- Target: 1 ns clock period. Flop characteristics are Tsu 190 ps, Th 10 ps (budget 100 ps), Tclk→Q 670 ps.
- The block adds no extra logic between flops, to maximize resolution time.

## Test plan
- **Power-on reset:** `async_in`=0, `n_rst`=0 mid-cycle → `sync_out`=0 within 0.5 cycle. Still 0 after a full clock cycle in reset. Still 0 just after `n_rst` is released 0.2 ns past a rising edge.
- **Normal 1:** after reset, set `async_in`=1 at a falling edge → `sync_out`=0 after the first rising edge, and `sync_out`=1 when checked 0.81 ns after the second rising edge.
- **Setup violations:**
  - Hold `async_in`=1, then drop it to 0 within 95 ps before a rising edge → two edges later, `sync_out` is 0 or 1 (never X). One edge after that, it is 0.
  - Repeat with 0→1 → same checks, settling to 1.
- **Hold violations:**
  - Change `async_in` 0→1 50 ps after a rising edge → two edges later, `sync_out` is a legal 0/1, and it settles to 1.
  - Repeat with 1→0 → same checks, settling to 0.
- **Metastable stream:** after reset, drive `async_in`=X at a falling edge and hold it for 200 cycles → at every check point (0.81 ns after each rising edge), `sync_out` is 0 (never X/Z). Then drive `async_in`=1 → `sync_out`=1 two edges later.
- **Reset mid-operation:** with `sync_out`=1 and `async_in`=1, assert `n_rst`=0 between edges → `sync_out`=0 immediately and held through 3 edges. On release, `sync_out` returns to 1 only after 2 rising edges.
